// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch/countdown timer.
// Digits are 4-bit BCD and are always kept inside 0..9.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // Non-decimal preset codes (A-F) saturate to 9 rather than wrapping.
  function automatic bcd_t bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Command, preset-load and display-side signals of the BCD timer.
// The master is the front-panel/command side; the slave is the timer controller.
interface bcd_timer_ctrl_if;
  import bcd_timer_pkg::*;

  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_clear;
  logic       dir_up;
  logic       load_valid;
  logic       load_ready;
  bcd_t       load_tens;
  bcd_t       load_ones;
  logic       lap;
  bcd_t       tens;
  bcd_t       ones;
  bcd_t       lap_tens;
  bcd_t       lap_ones;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       wrap;

  modport master (
    output cmd_start, cmd_stop, cmd_clear, dir_up,
    output load_valid, load_tens, load_ones, lap,
    input  load_ready, tens, ones, lap_tens, lap_ones,
    input  state, running, done, wrap
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, dir_up,
    input  load_valid, load_tens, load_ones, lap,
    output load_ready, tens, ones, lap_tens, lap_ones,
    output state, running, done, wrap
  );

endinterface

// File: rtl/bcd2_updown.sv
// Two-digit BCD up/down counter with synchronous clear and load, tick enable,
// and a flag telling whether the next enabled step reaches the terminal value.
module bcd2_updown
  import bcd_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  bcd_t load_tens,
  input  bcd_t load_ones,
  input  logic en,
  input  logic dir_up,
  output bcd_t tens,
  output bcd_t ones,
  output logic next_terminal,
  output logic is_zero
);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear) begin
      tens_d = BCD_ZERO;
      ones_d = BCD_ZERO;
    end else if (load) begin
      tens_d = bcd_clamp(load_tens);
      ones_d = bcd_clamp(load_ones);
    end else if (en) begin
      if (dir_up) begin
        if (ones_q == BCD_MAX) begin
          ones_d = BCD_ZERO;
          tens_d = (tens_q == BCD_MAX) ? BCD_ZERO : tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        // Borrowing below 00 wraps to 99 so digits stay decimal on every path.
        if (ones_q == BCD_ZERO) begin
          ones_d = BCD_MAX;
          tens_d = (tens_q == BCD_ZERO) ? BCD_MAX : tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= BCD_ZERO;
      ones_q <= BCD_ZERO;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens          = tens_q;
  assign ones          = ones_q;
  assign is_zero       = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);
  assign next_terminal = dir_up ? ((tens_q == BCD_MAX) && (ones_q == BCD_MAX))
                                : ((tens_q == BCD_ZERO) && (ones_q == 4'd1));

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch / countdown controller: command FSM, tick prescaler, preset-load
// handshake, lap snapshot and the done/wrap event pulses around a BCD counter.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  bcd_timer_ctrl_if.slave   bus
);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  timer_state_e  state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          dir_q, dir_d;
  bcd_t          lap_tens_q, lap_tens_d;
  bcd_t          lap_ones_q, lap_ones_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          load_ready_q, load_ready_d;

  logic cnt_clear, cnt_load, cnt_en;
  logic cnt_terminal, cnt_zero;
  logic tick, load_accept;
  bcd_t cnt_tens, cnt_ones;

  bcd2_updown u_count (
    .clk           (clk),
    .rst           (rst),
    .clear         (cnt_clear),
    .load          (cnt_load),
    .load_tens     (bus.load_tens),
    .load_ones     (bus.load_ones),
    .en            (cnt_en),
    .dir_up        (dir_q),
    .tens          (cnt_tens),
    .ones          (cnt_ones),
    .next_terminal (cnt_terminal),
    .is_zero       (cnt_zero)
  );

  assign tick        = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign load_accept = bus.load_valid && load_ready_q;

  // Priority: clear, then load accept, then stop, then start.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    dir_d      = dir_q;
    lap_tens_d = lap_tens_q;
    lap_ones_d = lap_ones_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    if (bus.cmd_clear) begin
      state_d   = ST_IDLE;
      pre_d     = '0;
      cnt_clear = 1'b1;
    end else if (load_accept) begin
      cnt_load = 1'b1;
      pre_d    = '0;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cmd_start && (bus.dir_up || !cnt_zero)) begin
            dir_d   = bus.dir_up;
            pre_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            pre_d  = '0;
            cnt_en = 1'b1;
            if (cnt_terminal && dir_q) begin
              wrap_d = 1'b1;
            end else if (cnt_terminal) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (bus.cmd_stop && (state_d == ST_RUN)) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (bus.cmd_start) state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    // Lap captures the count as it stood before this edge, even on a tick.
    if (bus.lap && !bus.cmd_clear && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
      lap_tens_d = cnt_tens;
      lap_ones_d = cnt_ones;
    end

    running_d    = (state_d == ST_RUN);
    load_ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      dir_q        <= 1'b1;
      lap_tens_q   <= BCD_ZERO;
      lap_ones_q   <= BCD_ZERO;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      dir_q        <= dir_d;
      lap_tens_q   <= lap_tens_d;
      lap_ones_q   <= lap_ones_d;
      running_q    <= running_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign bus.tens       = cnt_tens;
  assign bus.ones       = cnt_ones;
  assign bus.lap_tens   = lap_tens_q;
  assign bus.lap_ones   = lap_ones_q;
  assign bus.state      = state_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.wrap       = wrap_q;
  assign bus.load_ready = load_ready_q;

endmodule
